// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings, bridge state type and the HPROT->PPROT mapping.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

    // PPROT = {instruction, non-secure, privileged}
    function automatic logic [2:0] pprot_map(input logic [1:0] hprot);
        return {~hprot[0], 1'b1, hprot[1]};
    endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// Byte-lane strobe generation from AHB size and low address bits; flags sizes wider than a word.
module apb_strb_gen
    import ahb_apb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] haddr_lo,
    input  logic       hwrite,
    output logic [3:0] strb,
    output logic       size_err
);

    always_comb begin
        strb     = 4'b0000;
        size_err = 1'b0;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << haddr_lo;
            HSIZE_HALF: strb = 4'b0011 << {haddr_lo[1], 1'b0};
            HSIZE_WORD: strb = 4'b1111;
            default:    size_err = 1'b1;
        endcase
        if (!hwrite) strb = 4'b0000;
    end

endmodule

// File: rtl/ahb2apb_bridge_mc.sv
// AHB-Lite to APB3/APB4 bridge with one-hot PSEL decode, PREADY waits, PSLVERR->ERROR and PCLKEN timing.
// state  | meaning
// IDLE   | ready, sampling for a new transfer
// WAIT   | data phase, capture HWDATA, wait for PCLKEN (or fault decode/size)
// SETUP  | APB setup phase
// ACCESS | APB access phase, waits on PCLKEN & PREADY
// DONE   | OKAY completion, may accept the next transfer
// ERR1   | first ERROR cycle (HREADYOUT low)
// ERR2   | second ERROR cycle (HREADYOUT high)
module ahb2apb_bridge_mc
    import ahb_apb_pkg::*;
#(
    parameter int ADDRWIDTH      = 16,
    parameter int DATAWIDTH      = 32,
    parameter int NUM_SLV        = 4,
    parameter int SLV_LSB        = 12,
    parameter int REGISTER_RDATA = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic [DATAWIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [DATAWIDTH-1:0] HRDATA,
    input  logic                 PCLKEN,
    output logic [NUM_SLV-1:0]   PSEL,
    output logic                 PENABLE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PWRITE,
    output logic [DATAWIDTH-1:0] PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    input  logic [DATAWIDTH-1:0] PRDATA,
    output logic                 APBACTIVE
);

    // The whole field above SLV_LSB is decoded so out-of-range indices fault instead of aliasing.
    localparam int IDX_W = ADDRWIDTH - SLV_LSB;

    bridge_state_t state, state_nxt;

    logic             acc;
    logic             latch_xfer;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_q;
    logic             idx_oob;
    logic             dec_err_q;
    logic [3:0]       strb_d;
    logic             size_err_d;
    logic             hreadyout_c;
    logic             hresp_c;
    logic             penable_c;
    logic             sel_on;
    logic             apbactive_c;
    logic             unused_hprot;

    assign acc        = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign latch_xfer = acc & ((state == ST_IDLE) | (state == ST_DONE));
    assign idx_d      = HADDR[ADDRWIDTH-1:SLV_LSB];
    assign idx_oob    = 32'(idx_d) >= 32'(NUM_SLV);
    assign unused_hprot = ^HPROT[3:2];

    apb_strb_gen u_strb_gen (
        .hsize    (HSIZE),
        .haddr_lo (HADDR[1:0]),
        .hwrite   (HWRITE),
        .strb     (strb_d),
        .size_err (size_err_d)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        hreadyout_c = 1'b1;
        hresp_c     = 1'b0;
        penable_c   = 1'b0;
        sel_on      = 1'b0;
        apbactive_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                hreadyout_c = 1'b0;
                apbactive_c = 1'b1;
                if (dec_err_q)   state_nxt = ST_ERR1;
                else if (PCLKEN) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                hreadyout_c = 1'b0;
                apbactive_c = 1'b1;
                sel_on      = 1'b1;
                if (PCLKEN) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                hreadyout_c = 1'b0;
                apbactive_c = 1'b1;
                sel_on      = 1'b1;
                penable_c   = 1'b1;
                if (PCLKEN & PREADY) state_nxt = PSLVERR ? ST_ERR1 : ST_DONE;
            end
            ST_DONE: begin
                state_nxt = acc ? ST_WAIT : ST_IDLE;
            end
            ST_ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = 1'b1;
                state_nxt   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_c   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign HREADYOUT = hreadyout_c;
    assign HRESP     = hresp_c;
    assign PENABLE   = penable_c;
    assign APBACTIVE = apbactive_c;

    always_comb begin
        PSEL = '0;
        if (sel_on) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if (idx_q == IDX_W'(i)) PSEL[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PSTRB     <= 4'b0000;
            PPROT     <= 3'b000;
            PWDATA    <= '0;
            idx_q     <= '0;
            dec_err_q <= 1'b0;
        end else begin
            if (latch_xfer) begin
                PADDR     <= {HADDR[ADDRWIDTH-1:2], 2'b00};
                PWRITE    <= HWRITE;
                PSTRB     <= strb_d;
                PPROT     <= pprot_map(HPROT[1:0]);
                idx_q     <= idx_d;
                dec_err_q <= idx_oob | size_err_d;
            end
            if (state == ST_WAIT) PWDATA <= HWDATA;
        end
    end

    if (REGISTER_RDATA != 0) begin : g_rdata_reg
        logic rd_capture;
        assign rd_capture = (state == ST_ACCESS) & PCLKEN & PREADY & ~PSLVERR & ~PWRITE;

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn)        HRDATA <= '0;
            else if (rd_capture) HRDATA <= PRDATA;
        end
    end else begin : g_rdata_comb
        assign HRDATA = PRDATA;
    end

endmodule
